// File: rtl/inst_fetch_if.sv
// Instruction ROM port bundle: chip enable and byte address out, read word back.
// master = fetch unit (drives ce/addr), slave = ROM (returns inst combinationally).
interface inst_fetch_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              ce;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       inst;

    modport master (
        output ce,
        output addr,
        input  inst
    );

    modport slave (
        input  ce,
        input  addr,
        output inst
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives the ROM port, fills IF/ID.
// Ports: clk, rst (async active-low), stall/flush/new_pc, branch_flag/target,
// rom (ce/addr/inst), if_pc/if_inst/if_valid (IF/ID), misaligned.
// Optional INST_ALIGN_CHECK_EN: misaligned PC issues a NOP and parks until flush.
module inst_fetch #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    inst_fetch_if.master      rom,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_inst,
    output logic              if_valid,
    output logic              misaligned
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              ce_q, ce_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [31:0]       if_inst_q, if_inst_d;
    logic              if_valid_q, if_valid_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              mis_q, mis_d;
    logic              park;

`ifdef INST_ALIGN_CHECK_EN
    assign park = (pc_q[1:0] != 2'b00);
`else
    assign park = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ce_d       = ce_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        mis_d      = mis_q;

        unique case (state_q)
            IDLE: begin
                state_d = RUN;
                ce_d    = 1'b1;
            end
            RUN: begin
                if (flush) begin
                    pc_d       = new_pc;
                    if_pc_d    = '0;
                    if_inst_d  = '0;
                    if_valid_d = 1'b0;
                    pend_d     = 1'b0;
                    mis_d      = 1'b0;
                end else if (stall) begin
                    // Remember the most recent redirect seen while frozen.
                    if (branch_flag) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = branch_target;
                    end
                end else if (park) begin
                    // Issue a NOP for the bad address and hold pc for a flush.
                    if_pc_d    = pc_q;
                    if_inst_d  = '0;
                    if_valid_d = 1'b1;
                    mis_d      = 1'b1;
                end else begin
                    // Delay slot: the word at pc is always issued.
                    if_pc_d    = pc_q;
                    if_inst_d  = rom.inst;
                    if_valid_d = 1'b1;
                    pend_d     = 1'b0;
                    if (branch_flag) begin
                        pc_d = branch_target;
                    end else if (pend_q) begin
                        pc_d = pend_tgt_q;
                    end else begin
                        pc_d = pc_q + ADDR_W'(4);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ce_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ce_q       <= 1'b0;
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
            if_valid_q <= 1'b0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ce_q       <= ce_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            mis_q      <= mis_d;
        end
    end

    assign rom.ce     = ce_q;
    assign rom.addr   = pc_q;
    assign if_pc      = if_pc_q;
    assign if_inst    = if_inst_q;
    assign if_valid   = if_valid_q;
    assign misaligned = mis_q;

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch initiator for the instruction ROM port: owns the PC, drives ROM chip-enable and byte address, and samples the returned word into the IF/ID pipeline register.
- Sits between the ROM and the decode stage. Handles pipeline stall, branch redirect (with a pending-branch buffer across stalls) and exception flush.
- The ROM port is combinational: `inst` is valid in the same cycle as `addr`.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- ADDR_W, 32, width of PC/addr/target buses.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and IF/ID register.
- flush  in  1  exception flush; load new_pc.
- new_pc  in  ADDR_W  flush target.
- branch_flag  in  1  branch taken, from decode.
- branch_target  in  ADDR_W  branch byte address.
- ce  out  1  ROM chip enable, registered.
- addr  out  ADDR_W  ROM byte address, equals PC register.
- inst  in  32  ROM read data, combinational.
- if_pc  out  ADDR_W  PC of the instruction held in IF/ID.
- if_inst  out  32  instruction held in IF/ID.
- if_valid  out  1  IF/ID holds a real instruction.
- misaligned  out  1  fetch address low bits nonzero (see feature).

Behaviour:
- Reset (rst=0, async):
  - ce=0, pc=RESET_PC, if_pc=0, if_inst=0, if_valid=0, misaligned=0.
  - Pending-branch register is cleared.
- States:
  - IDLE: ce=0. First clock after rst deasserts: ce<=1, go RUN. pc does not advance in IDLE.
  - RUN: ce=1. Stays in RUN until reset.
- addr = pc at all times. With ce=0, inst is ignored.
- In RUN, clock-edge priority is flush > stall > branch > sequential:
  - flush: pc<=new_pc; if_inst<=0; if_valid<=0; if_pc<=0; pending cleared. Applies even while stalled.
  - stall (no flush): pc, if_* and state hold. If branch_flag=1, latch branch_target into the pending register. The last branch received wins.
  - Not stalled: IF/ID<=(pc, inst, valid=1). This is the delay-slot capture: the instruction at pc is always issued.
    - Next pc: branch_target if branch_flag=1; else the pending target if pending is set; else pc+4.
    - Pending is cleared on this edge.
- pc+4 wraps modulo 2^ADDR_W: 32'hFFFF_FFFC -> 32'h0000_0000.
- Latency: instruction at address A appears on if_inst one clock after pc=A on an unstalled edge.
- Reset mid-operation: immediate return to the reset values. The first fetch after release is RESET_PC.

Optional Feature:
- Macro: INST_ALIGN_CHECK_EN.
- Defined:
  - When pc[1:0]!=0 in RUN and not stalled, IF/ID captures if_inst=0 (NOP), if_valid=1, if_pc=pc, and misaligned<=1.
  - pc then holds its value until a flush arrives.
  - misaligned clears on flush or reset.
- Undefined:
  - misaligned is tied to 0.
  - pc[1:0] is forwarded unchanged; the ROM ignores the low bits, so the word at addr[ADDR_W-1:2] is fetched.

Test Plan:
- Reset release, ROM word[i]=32'h1000_0000+i:
  - Cycle 1: ce=1.
  - Following edges: (if_pc,if_inst) = (0,10000000), (4,10000001), (8,10000002); if_valid=1 from the second edge.
- Branch at pc=8, branch_flag=1, target=32'h40:
  - Next edge: if_pc=8 (delay slot) and pc=32'h40.
  - Edge after: if_inst=10000010.
- stall high 3 cycles while branch_flag pulses target=32'h80 in stall cycle 2:
  - if_* and pc frozen throughout the stall.
  - First unstalled edge: pc=32'h80.
- flush with new_pc=32'h180 while stall=1 and a branch is pending:
  - Next edge: pc=32'h180, if_valid=0, if_inst=0, pending cleared.
  - Following edge: if_inst=10000060.
- RESET_PC=32'hFFFF_FFFC, rom index wrap:
  - Fetch sequence is pc FFFF_FFFC then 0000_0000, with no stall or error.
- INST_ALIGN_CHECK_EN defined, branch target=32'h42:
  - if_inst=0, if_valid=1, misaligned=1; pc holds at 32'h42.
  - Flush to 32'h0: misaligned=0 and fetch resumes.
